// File: rtl/spi_frame_controller.sv
// SPI frame controller: decodes address, opcode and data bytes of a cs-low
// frame into write strobes and per-channel ready handshakes.
module spi_frame_controller #(
   parameter int         ADDR_BYTES   = 2,
   parameter int         NUM_CH       = 3,
   parameter logic [7:0] OP_WRITE     = 8'h01,
   parameter logic [7:0] OP_CH_BASE   = 8'h05,
   parameter int         OP_CH_STRIDE = 2,
   parameter bit         BURST_EN     = 1'b1,
   localparam int        AW           = 8 * ADDR_BYTES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cs,
   input  logic                  data_valid,
   input  logic [7:0]            data_in,
   output logic [ADDR_BYTES-1:0] addr_byte_en,
   output logic                  instr_reg_en,
   output logic [7:0]            instr_out,
   output logic [AW-1:0]         mem_addr,
   output logic                  write_memory_enable,
   output logic [NUM_CH-1:0]     ready,
   output logic [NUM_CH-1:0]     ready_en,
   output logic                  busy,
   output logic                  frame_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_INSTR,
      S_DATA,
      S_SYNC,
      S_DRAIN
   } state_t;

   localparam int BW = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [ADDR_BYTES-1:0] AB_MSB =
      ADDR_BYTES'(1) << (ADDR_BYTES - 1);
   localparam logic [NUM_CH-1:0] CH_ONE = NUM_CH'(1);

   function automatic logic [7:0] ch_op(input int k);
      return OP_CH_BASE + 8'(k * OP_CH_STRIDE);
   endfunction

   state_t                state_q, state_d;
   logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic [CW-1:0]         ch_q, ch_d;
   logic                  is_ch_q, is_ch_d;

   logic [ADDR_BYTES-1:0] addr_byte_en_q, addr_byte_en_d;
   logic                  instr_reg_en_q, instr_reg_en_d;
   logic [7:0]            instr_out_q, instr_out_d;
   logic [AW-1:0]         mem_addr_q, mem_addr_d;
   logic                  wr_en_q, wr_en_d;
   logic [NUM_CH-1:0]     ready_q, ready_d;
   logic [NUM_CH-1:0]     ready_en_q, ready_en_d;
   logic                  busy_q, busy_d;
   logic                  frame_error_q, frame_error_d;

   logic                  op_is_wr;
   logic                  op_is_ch;
   logic [CW-1:0]         op_ch;

   // Full 8-bit opcode match against plain write and every channel opcode
   always_comb begin
      op_is_wr = (data_in == OP_WRITE);
      op_is_ch = 1'b0;
      op_ch    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!op_is_ch && data_in == ch_op(k)) begin
            op_is_ch = 1'b1;
            op_ch    = CW'(k);
         end
      end
   end

   // Next-state and registered-output computation for the frame sequencer
   always_comb begin
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      addr_d         = addr_q;
      ch_d           = ch_q;
      is_ch_d        = is_ch_q;
      instr_out_d    = instr_out_q;
      mem_addr_d     = mem_addr_q;
      addr_byte_en_d = '0;
      instr_reg_en_d = 1'b0;
      wr_en_d        = 1'b0;
      ready_d        = '0;
      ready_en_d     = '0;
      frame_error_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!cs) begin
               state_d    = S_ADDR;
               byte_cnt_d = '0;
               addr_d     = '0;
            end
         end
         S_ADDR: begin
            if (cs) begin
               frame_error_d = 1'b1;
               addr_d        = '0;
               state_d       = S_IDLE;
            end else if (data_valid) begin
               addr_d         = (addr_q << 8) | AW'(data_in);
               addr_byte_en_d = AB_MSB >> byte_cnt_q;
               byte_cnt_d     = byte_cnt_q + BW'(1);
               if (byte_cnt_q == BW'(ADDR_BYTES - 1)) begin
                  state_d = S_INSTR;
               end
            end
         end
         S_INSTR: begin
            if (cs) begin
               frame_error_d = 1'b1;
               addr_d        = '0;
               state_d       = S_IDLE;
            end else if (data_valid) begin
               instr_reg_en_d = 1'b1;
               instr_out_d    = data_in;
               if (op_is_wr) begin
                  is_ch_d = 1'b0;
                  state_d = S_DATA;
               end else if (op_is_ch) begin
                  is_ch_d    = 1'b1;
                  ch_d       = op_ch;
                  ready_en_d = CH_ONE << op_ch;
                  state_d    = S_DATA;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = S_DRAIN;
               end
            end
         end
         S_DATA: begin
            if (cs) begin
               state_d = S_IDLE;
            end else if (data_valid) begin
               wr_en_d    = 1'b1;
               mem_addr_d = addr_q;
               if (is_ch_q) begin
                  state_d = S_SYNC;
               end else if (BURST_EN) begin
                  addr_d = addr_q + AW'(1);
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_SYNC: begin
            ready_d    = CH_ONE << ch_q;
            ready_en_d = CH_ONE << ch_q;
            state_d    = S_DRAIN;
         end
         S_DRAIN: begin
            if (cs) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         byte_cnt_q     <= '0;
         addr_q         <= '0;
         ch_q           <= '0;
         is_ch_q        <= 1'b0;
         addr_byte_en_q <= '0;
         instr_reg_en_q <= 1'b0;
         instr_out_q    <= '0;
         mem_addr_q     <= '0;
         wr_en_q        <= 1'b0;
         ready_q        <= '0;
         ready_en_q     <= '0;
         busy_q         <= 1'b0;
         frame_error_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         addr_q         <= addr_d;
         ch_q           <= ch_d;
         is_ch_q        <= is_ch_d;
         addr_byte_en_q <= addr_byte_en_d;
         instr_reg_en_q <= instr_reg_en_d;
         instr_out_q    <= instr_out_d;
         mem_addr_q     <= mem_addr_d;
         wr_en_q        <= wr_en_d;
         ready_q        <= ready_d;
         ready_en_q     <= ready_en_d;
         busy_q         <= busy_d;
         frame_error_q  <= frame_error_d;
      end
   end

   assign addr_byte_en        = addr_byte_en_q;
   assign instr_reg_en        = instr_reg_en_q;
   assign instr_out           = instr_out_q;
   assign mem_addr            = mem_addr_q;
   assign write_memory_enable = wr_en_q;
   assign ready               = ready_q;
   assign ready_en            = ready_en_q;
   assign busy                = busy_q;
   assign frame_error         = frame_error_q;

endmodule

// File: tb/tb_spi_frame_controller.sv
// Scoreboard bench for spi_frame_controller: expected strobe events are
// queued by the stimulus and popped by a monitor as the DUT emits them.
module tb_spi_frame_controller;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        data_valid;
   logic [7:0]  data_in;
   logic [1:0]  addr_byte_en;
   logic        instr_reg_en;
   logic [7:0]  instr_out;
   logic [15:0] mem_addr;
   logic        write_memory_enable;
   logic [2:0]  ready;
   logic [2:0]  ready_en;
   logic        busy;
   logic        frame_error;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [1:0]  abe;
      logic        ire;
      logic [7:0]  ins;
      logic        wme;
      logic [15:0] ma;
      logic [2:0]  rdy;
      logic [2:0]  ren;
      logic        fe;
   } ev_t;

   ev_t exp_q[$];

   spi_frame_controller dut (
      .clk                 (clk),
      .reset               (reset),
      .cs                  (cs),
      .data_valid          (data_valid),
      .data_in             (data_in),
      .addr_byte_en        (addr_byte_en),
      .instr_reg_en        (instr_reg_en),
      .instr_out           (instr_out),
      .mem_addr            (mem_addr),
      .write_memory_enable (write_memory_enable),
      .ready               (ready),
      .ready_en            (ready_en),
      .busy                (busy),
      .frame_error         (frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic x_abe(input logic [1:0] v);
      ev_t e;
      e = '0;
      e.abe = v;
      exp_q.push_back(e);
   endtask

   task automatic x_ins(input logic [7:0] op, input logic [2:0] ren,
                        input logic fe);
      ev_t e;
      e = '0;
      e.ire = 1'b1;
      e.ins = op;
      e.ren = ren;
      e.fe = fe;
      exp_q.push_back(e);
   endtask

   task automatic x_wr(input logic [15:0] a);
      ev_t e;
      e = '0;
      e.wme = 1'b1;
      e.ma = a;
      exp_q.push_back(e);
   endtask

   task automatic x_rdy(input logic [2:0] v);
      ev_t e;
      e = '0;
      e.rdy = v;
      e.ren = v;
      exp_q.push_back(e);
   endtask

   task automatic x_err();
      ev_t e;
      e = '0;
      e.fe = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb(input logic [7:0] b);
      data_valid = 1'b1;
      data_in = b;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic start();
      cs = 1'b0;
      tick(1);
   endtask

   task automatic stop();
      cs = 1'b1;
      tick(2);
   endtask

   // Monitor: every cycle with any strobe active must match the queue head
   always @(negedge clk) begin
      ev_t o;
      o = '0;
      o.abe = addr_byte_en;
      o.ire = instr_reg_en;
      o.ins = instr_reg_en ? instr_out : 8'h00;
      o.wme = write_memory_enable;
      o.ma = write_memory_enable ? mem_addr : 16'h0000;
      o.rdy = ready;
      o.ren = ready_en;
      o.fe = frame_error;
      if (|{o.abe, o.ire, o.wme, o.rdy, o.ren, o.fe}) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", 64'(o), 64'h0);
         end else begin
            chk("event", 64'(o), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      reset = 1'b0;
      cs = 1'b1;
      data_valid = 1'b0;
      data_in = 8'h00;
      tick(3);
      chk("rst_abe", 64'(addr_byte_en), 64'h0);
      chk("rst_instr", 64'(instr_out), 64'h0);
      chk("rst_maddr", 64'(mem_addr), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_ready", 64'({ready, ready_en}), 64'h0);
      reset = 1'b1;
      tick(1);

      // Single write frame
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h01, 3'b000, 1'b0);
      x_wr(16'h1234);
      start();
      chk("busy_frame", 64'(busy), 64'h1);
      sb(8'h12); sb(8'h34); sb(8'h01); sb(8'hAA);
      stop();
      chk("busy_idle", 64'(busy), 64'h0);
      chk("instr_latched", 64'(instr_out), 64'h01);

      // Burst with address wrap
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h01, 3'b000, 1'b0);
      x_wr(16'hFFFE); x_wr(16'hFFFF); x_wr(16'h0000);
      start();
      sb(8'hFF); sb(8'hFE); sb(8'h01);
      sb(8'h11); sb(8'h22); sb(8'h33);
      stop();

      // Channel 1 handshake, trailing bytes ignored
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h07, 3'b010, 1'b0);
      x_wr(16'h0040); x_rdy(3'b010);
      start();
      sb(8'h00); sb(8'h40); sb(8'h07); sb(8'h3C);
      tick(1);
      sb(8'h55); sb(8'h66);
      chk("busy_drain_ch", 64'(busy), 64'h1);
      stop();

      // Channel 2
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h09, 3'b100, 1'b0);
      x_wr(16'h0102); x_rdy(3'b100);
      start();
      sb(8'h01); sb(8'h02); sb(8'h09); sb(8'h77);
      stop();

      // Invalid opcode
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h02, 3'b000, 1'b1);
      start();
      sb(8'h00); sb(8'h00); sb(8'h02); sb(8'h10); sb(8'h20);
      chk("busy_drain_err", 64'(busy), 64'h1);
      stop();
      chk("instr_bad", 64'(instr_out), 64'h02);

      // Abort after first address byte, then a clean frame
      x_abe(2'b10); x_err();
      start();
      sb(8'hAB);
      stop();
      chk("busy_abort", 64'(busy), 64'h0);
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h01, 3'b000, 1'b0);
      x_wr(16'h5678);
      start();
      sb(8'h56); sb(8'h78); sb(8'h01); sb(8'h99);
      stop();

      // cs rise together with a burst byte drops that byte
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h01, 3'b000, 1'b0);
      x_wr(16'h2000); x_wr(16'h2001);
      start();
      sb(8'h20); sb(8'h00); sb(8'h01); sb(8'h01); sb(8'h02);
      cs = 1'b1;
      sb(8'h03);
      tick(2);

      // Reset while in DATA clears everything
      x_abe(2'b10); x_abe(2'b01); x_ins(8'h01, 3'b000, 1'b0);
      start();
      sb(8'h30); sb(8'h00); sb(8'h01);
      reset = 1'b0;
      sb(8'h44);
      chk("rst_mid_wme", 64'(write_memory_enable), 64'h0);
      chk("rst_mid_busy", 64'(busy), 64'h0);
      chk("rst_mid_instr", 64'(instr_out), 64'h0);
      chk("rst_mid_maddr", 64'(mem_addr), 64'h0);
      cs = 1'b1;
      tick(1);
      reset = 1'b1;
      tick(3);

      chk("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
